// File: rtl/bp_pkg.sv
// Shared types and helpers for the two-level branch predictor update path:
// 2-bit counter encoding, the update FSM states and the saturating-counter step.
package bp_pkg;

    localparam int BHT_DEPTH_DEF  = 10;
    localparam int PHT_DEPTH_DEF  = 6;
    localparam int FIFO_DEPTH_DEF = 4;

    // Gray-style encoding: the MSB is the predicted direction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b11,
        ST  = 2'b10
    } ctr_e;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        READ,
        UPDATE
    } state_e;

    function automatic logic [1:0] next_ctr(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        case (ctr)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            default: nxt = taken ? ST  : WT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Circular outcome queue; pointers carry an extra wrap bit so full and empty
// are distinguishable without a separate counter register.
module bp_upd_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_q, wr_d;
    logic [PW:0]      rd_q, rd_d;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign count = wr_q - rd_q;
    assign head  = mem_q[rd_q[PW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push && !full) wr_d = wr_q + (PW+1)'(1);
        if (pop && !empty) rd_d = rd_q + (PW+1)'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !full) mem_q[wr_q[PW-1:0]] <= din;
    end

endmodule

// File: rtl/bp_update_ctrl.sv
// Serialises resolved branch outcomes into BHT/PHT read-modify-writes and
// walks both tables to clear them after reset.
module bp_update_ctrl
    import bp_pkg::*;
#(
    parameter int BHT_DEPTH  = BHT_DEPTH_DEF,
    parameter int PHT_DEPTH  = PHT_DEPTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 branchM,
    input  logic                 stallM,
    input  logic [31:0]          pcM,
    input  logic                 actual_takeM,
    input  logic                 pred_takeM,
    output logic                 upd_stall,
    output logic                 init_done,
    output logic [BHT_DEPTH-1:0] bht_raddr,
    input  logic [PHT_DEPTH-1:0] bht_rdata,
    output logic                 bht_we,
    output logic [BHT_DEPTH-1:0] bht_waddr,
    output logic [PHT_DEPTH-1:0] bht_wdata,
    output logic [PHT_DEPTH-1:0] pht_raddr,
    input  logic [1:0]           pht_rdata,
    output logic                 pht_we,
    output logic [PHT_DEPTH-1:0] pht_waddr,
    output logic [1:0]           pht_wdata,
    output logic [31:0]          branch_cnt,
    output logic [31:0]          mispred_cnt
);

    localparam int EW = BHT_DEPTH + 2;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BHT_DEPTH:0] PHT_ENTRIES = (BHT_DEPTH+1)'(1) << PHT_DEPTH;

    state_e               state_q, state_d;
    logic [BHT_DEPTH-1:0] idx_q, idx_d;
    logic                 started_q, started_d;
    logic                 init_done_q, init_done_d;
    logic [PHT_DEPTH-1:0] bhr_q, bhr_d;
    logic [31:0]          branch_cnt_q, branch_cnt_d;
    logic [31:0]          mispred_cnt_q, mispred_cnt_d;

    logic                 fifo_full, fifo_empty, push, pop;
    logic [EW-1:0]        fifo_head;
    logic [CW-1:0]        fifo_count;
    logic [BHT_DEPTH-1:0] head_idx;
    logic                 head_act, head_pred;
    logic                 unused_pc;

    assign unused_pc = ^{pcM[31:BHT_DEPTH+2], pcM[1:0]};

    // Full is the pre-edge view, so a same-cycle pop never admits this push.
    assign push      = branchM & ~stallM & ~fifo_full;
    assign upd_stall = branchM & ~stallM & fifo_full;

    bp_upd_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({pcM[BHT_DEPTH+1:2], actual_takeM, pred_takeM}),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head),
        .count (fifo_count)
    );

    assign head_idx  = fifo_head[EW-1:2];
    assign head_act  = fifo_head[1];
    assign head_pred = fifo_head[0];

    assign bht_raddr   = head_idx;
    assign pht_raddr   = bhr_q;
    assign init_done   = init_done_q;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        started_d     = 1'b1;
        init_done_d   = init_done_q;
        bhr_d         = bhr_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        pop           = 1'b0;
        bht_we        = 1'b0;
        bht_waddr     = head_idx;
        bht_wdata     = {bhr_q[PHT_DEPTH-2:0], head_act};
        pht_we        = 1'b0;
        pht_waddr     = bhr_q;
        pht_wdata     = next_ctr(pht_rdata, head_act);

        case (state_q)
            INIT: begin
                // The cycle reset is released writes nothing; the walk starts one edge later.
                if (started_q) begin
                    bht_we    = 1'b1;
                    bht_waddr = idx_q;
                    bht_wdata = '0;
                    pht_we    = ({1'b0, idx_q} < PHT_ENTRIES);
                    pht_waddr = idx_q[PHT_DEPTH-1:0];
                    pht_wdata = WT;
                    if (idx_q == '1) begin
                        state_d     = IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + BHT_DEPTH'(1);
                    end
                end
            end
            IDLE: begin
                if (!fifo_empty) state_d = READ;
            end
            READ: begin
                bhr_d   = bht_rdata;
                state_d = UPDATE;
            end
            UPDATE: begin
                pht_we        = 1'b1;
                bht_we        = 1'b1;
                pop           = 1'b1;
                branch_cnt_d  = branch_cnt_q + 32'd1;
                mispred_cnt_d = mispred_cnt_q + 32'(head_pred ^ head_act);
                state_d       = (push || (fifo_count > CW'(1))) ? READ : IDLE;
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= INIT;
            idx_q         <= '0;
            started_q     <= 1'b0;
            init_done_q   <= 1'b0;
            bhr_q         <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            started_q     <= started_d;
            init_done_q   <= init_done_d;
            bhr_q         <= bhr_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed bench for bp_update_ctrl: behavioural BHT/PHT arrays plus
// scenario tasks with hand-computed expectations.
module tb_bp_update_ctrl;

    localparam int BD = 10;
    localparam int PD = 6;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          branchM = 1'b0, stallM = 1'b0, actual_takeM = 1'b0, pred_takeM = 1'b0;
    logic [31:0]   pcM = '0;
    logic          upd_stall, init_done, bht_we, pht_we;
    logic [BD-1:0] bht_raddr, bht_waddr;
    logic [PD-1:0] bht_rdata, bht_wdata, pht_raddr, pht_waddr;
    logic [1:0]    pht_rdata, pht_wdata;
    logic [31:0]   branch_cnt, mispred_cnt;

    int compared   = 0;
    int mismatched = 0;

    logic [PD-1:0] bht_mem [2**BD] = '{default: 6'h2A};
    logic [1:0]    pht_mem [2**PD] = '{default: 2'b01};
    int            log_a   [64];
    int            log_n = 0;

    always #5 clk = ~clk;

    bp_update_ctrl #(.BHT_DEPTH(BD), .PHT_DEPTH(PD), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .branchM(branchM), .stallM(stallM), .pcM(pcM),
        .actual_takeM(actual_takeM), .pred_takeM(pred_takeM), .upd_stall(upd_stall),
        .init_done(init_done), .bht_raddr(bht_raddr), .bht_rdata(bht_rdata),
        .bht_we(bht_we), .bht_waddr(bht_waddr), .bht_wdata(bht_wdata),
        .pht_raddr(pht_raddr), .pht_rdata(pht_rdata), .pht_we(pht_we),
        .pht_waddr(pht_waddr), .pht_wdata(pht_wdata),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    assign bht_rdata = bht_mem[bht_raddr];
    assign pht_rdata = pht_mem[pht_raddr];

    always @(posedge clk) begin
        if (bht_we) bht_mem[bht_waddr] <= bht_wdata;
        if (pht_we) pht_mem[pht_waddr] <= pht_wdata;
        if (bht_we && init_done && log_n < 64) begin
            log_a[log_n] <= int'(bht_waddr);
            log_n        <= log_n + 1;
        end
    end

    task automatic drive(input logic br, input int idx, input logic act, input logic pred);
        branchM      = br;
        pcM          = 32'(idx) << 2;
        actual_takeM = act;
        pred_takeM   = pred;
    endtask

    task automatic test_reset();
        drive(1'b1, 5, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        compared++;
        if ({init_done, bht_we, pht_we, upd_stall} !== 4'b0000) begin
            mismatched++;
            $display("FAIL reset_flags: got %b want 0000", {init_done, bht_we, pht_we, upd_stall});
        end
        compared++;
        if ({branch_cnt, mispred_cnt} !== 64'd0) begin
            mismatched++;
            $display("FAIL reset_counts: got %0d/%0d want 0/0", branch_cnt, mispred_cnt);
        end
        drive(1'b0, 0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        compared++;
        if ({bht_we, pht_we} !== 2'b00) begin
            mismatched++;
            $display("FAIL release_cycle_we: got %b want 00", {bht_we, pht_we});
        end
    endtask

    // Walks the 1024-cycle clear; with fill set, queues 5 branches near its end.
    task automatic test_init(input bit fill);
        for (int i = 0; i < 2**BD; i++) begin
            @(negedge clk);
            compared++;
            if ({bht_we, bht_waddr, bht_wdata, pht_we, init_done} !==
                {1'b1, BD'(i), PD'(0), (i < 2**PD), 1'b0}) begin
                mismatched++;
                $display("FAIL init_walk[%0d]: got we=%b a=%0d d=%h pwe=%b done=%b", i,
                         bht_we, bht_waddr, bht_wdata, pht_we, init_done);
            end
            if (i < 2**PD) begin
                compared++;
                if ({pht_waddr, pht_wdata} !== {PD'(i), 2'b11}) begin
                    mismatched++;
                    $display("FAIL init_pht[%0d]: got a=%0d d=%b want a=%0d d=11", i,
                             pht_waddr, pht_wdata, i);
                end
            end
            if (fill && i >= 1010 && i <= 1014) begin
                drive(1'b1, 300 + i - 1010, 1'(i), 1'b0);
                #1;
                if (i >= 1013) begin
                    compared++;
                    if (upd_stall !== (i == 1014)) begin
                        mismatched++;
                        $display("FAIL fill_stall[%0d]: got %b want %b", i, upd_stall, (i == 1014));
                    end
                end
            end
        end
        if (!fill) begin
            @(negedge clk);
            compared++;
            if ({init_done, bht_we, pht_we} !== 3'b100) begin
                mismatched++;
                $display("FAIL init_done: got done/we/pwe=%b want 100", {init_done, bht_we, pht_we});
            end
            begin
                int bad = 0;
                for (int k = 0; k < 2**BD; k++) if (bht_mem[k] !== '0) bad++;
                for (int k = 0; k < 2**PD; k++) if (pht_mem[k] !== 2'b11) bad++;
                compared++;
                if (bad != 0) begin
                    mismatched++;
                    $display("FAIL table_clear: got %0d bad entries want 0", bad);
                end
            end
        end
    endtask

    task automatic test_single();
        drive(1'b1, 5, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 0, 1'b0, 1'b0);
        compared++;
        if ({bht_we, pht_we} !== 2'b00) begin
            mismatched++;
            $display("FAIL single_idle: got we=%b%b want 00", bht_we, pht_we);
        end
        @(negedge clk);
        compared++;
        if ({bht_we, pht_we, bht_raddr} !== {2'b00, BD'(5)}) begin
            mismatched++;
            $display("FAIL single_read: got we=%b%b raddr=%0d want 00/5", bht_we, pht_we, bht_raddr);
        end
        @(negedge clk);
        compared++;
        if ({pht_we, pht_waddr, pht_wdata, bht_we, bht_waddr, bht_wdata} !==
            {1'b1, PD'(0), 2'b10, 1'b1, BD'(5), 6'b000001}) begin
            mismatched++;
            $display("FAIL single_update: got pwe=%b pa=%0d pd=%b we=%b a=%0d d=%b",
                     pht_we, pht_waddr, pht_wdata, bht_we, bht_waddr, bht_wdata);
        end
        @(negedge clk);
        compared++;
        if ({bht_mem[5], pht_mem[0], branch_cnt, mispred_cnt, bht_we} !==
            {6'd1, 2'b10, 32'd1, 32'd1, 1'b0}) begin
            mismatched++;
            $display("FAIL single_commit: got bht=%b pht=%b cnt=%0d mis=%0d we=%b",
                     bht_mem[5], pht_mem[0], branch_cnt, mispred_cnt, bht_we);
        end
    endtask

    task automatic do_update(input int idx, input logic act, input logic pred,
                             input logic [1:0] exp_ctr);
        bit found = 0;
        drive(1'b1, idx, act, pred);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) drive(1'b0, 0, 1'b0, 1'b0);
            if (pht_we) begin
                found = 1;
                break;
            end
        end
        compared++;
        if (!found) begin
            mismatched++;
            $display("FAIL sat_timeout: got no pht_we want one within 8 cycles");
        end else begin
            compared++;
            if ({pht_waddr, pht_wdata, bht_waddr, bht_wdata} !== {PD'(0), exp_ctr, BD'(idx), PD'(0)}) begin
                mismatched++;
                $display("FAIL sat_step: got pa=%0d pd=%b a=%0d d=%b want 0/%b/%0d/0",
                         pht_waddr, pht_wdata, bht_waddr, bht_wdata, exp_ctr, idx);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        do_update(16, 1'b0, 1'b1, 2'b11);
        do_update(16, 1'b0, 1'b0, 2'b01);
        do_update(16, 1'b0, 1'b1, 2'b00);
        do_update(16, 1'b0, 1'b1, 2'b00);
        do_update(16, 1'b0, 1'b0, 2'b00);
        compared++;
        if ({pht_mem[0], branch_cnt, mispred_cnt} !== {2'b00, 32'd6, 32'd4}) begin
            mismatched++;
            $display("FAIL sat_final: got pht=%b cnt=%0d mis=%0d want 00/6/4",
                     pht_mem[0], branch_cnt, mispred_cnt);
        end
    endtask

    task automatic test_push_pop();
        int start = log_n;
        drive(1'b1, 100, 1'b1, 1'b1);
        @(negedge clk);
        drive(1'b1, 101, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        compared++;
        if ({bht_we, bht_waddr} !== {1'b1, BD'(100)}) begin
            mismatched++;
            $display("FAIL pp_update: got we=%b a=%0d want 1/100", bht_we, bht_waddr);
        end
        drive(1'b1, 102, 1'b1, 1'b1);
        #1;
        compared++;
        if (upd_stall !== 1'b0) begin
            mismatched++;
            $display("FAIL pp_stall: got %b want 0", upd_stall);
        end
        @(negedge clk);
        drive(1'b0, 0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        compared++;
        if (log_n - start != 3 || log_a[start] != 100 || log_a[start+1] != 101 ||
            log_a[start+2] != 102) begin
            mismatched++;
            $display("FAIL pp_order: got %0d writes first=%0d want 3 writes 100,101,102",
                     log_n - start, log_a[start]);
        end
        compared++;
        if ({branch_cnt, mispred_cnt} !== {32'd9, 32'd4}) begin
            mismatched++;
            $display("FAIL pp_counts: got %0d/%0d want 9/4", branch_cnt, mispred_cnt);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 5, 1'b1, 1'b1);
        @(negedge clk);
        drive(1'b1, 200, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 201, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 0, 1'b0, 1'b0);
        compared++;
        if ({bht_we, bht_waddr, pht_we} !== {1'b1, BD'(5), 1'b1}) begin
            mismatched++;
            $display("FAIL mid_in_update: got we=%b a=%0d pwe=%b want 1/5/1", bht_we, bht_waddr, pht_we);
        end
        #1 rst = 1'b1;
        #1;
        compared++;
        if ({bht_we, pht_we, init_done, branch_cnt, mispred_cnt} !== 67'd0) begin
            mismatched++;
            $display("FAIL mid_reset_vals: got we=%b%b done=%b cnt=%0d mis=%0d want all 0",
                     bht_we, pht_we, init_done, branch_cnt, mispred_cnt);
        end
        @(posedge clk);
        #1;
        compared++;
        if ({bht_mem[5], pht_mem[1]} !== {6'd1, 2'b11}) begin
            mismatched++;
            $display("FAIL mid_no_write: got bht=%b pht=%b want 000001/11", bht_mem[5], pht_mem[1]);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        compared++;
        if ({bht_we, pht_we} !== 2'b00) begin
            mismatched++;
            $display("FAIL mid_release_we: got %b want 00", {bht_we, pht_we});
        end
    endtask

    task automatic test_full();
        int start = log_n;
        int k;
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) begin
                compared++;
                if ({init_done, upd_stall} !== 2'b11) begin
                    mismatched++;
                    $display("FAIL full_after_init: got done/stall=%b want 11", {init_done, upd_stall});
                end
            end
            if (!upd_stall) break;
        end
        compared++;
        if (k != 3) begin
            mismatched++;
            $display("FAIL full_release: got stall cleared after %0d cycles want 3", k);
        end
        @(negedge clk);
        drive(1'b0, 0, 1'b0, 1'b0);
        repeat (12) @(negedge clk);
        begin
            int bad = (log_n - start != 5) ? 1 : 0;
            for (int j = 0; j < 5; j++) if (log_a[start+j] != 300 + j) bad++;
            compared++;
            if (bad != 0) begin
                mismatched++;
                $display("FAIL full_order: got %0d writes first=%0d want 5 writes 300..304",
                         log_n - start, log_a[start]);
            end
        end
        compared++;
        if ({branch_cnt, mispred_cnt} !== {32'd5, 32'd2}) begin
            mismatched++;
            $display("FAIL full_counts: got %0d/%0d want 5/2", branch_cnt, mispred_cnt);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_init(1'b0);
        test_single();
        test_saturation();
        test_push_pop();
        test_reset_mid();
        test_init(1'b1);
        test_full();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bp_update_ctrl.md
# bp_update_ctrl

Update scheduler for the two-level (BHT/PHT) branch predictor. It sits between the M stage and the predictor tables. It queues resolved branch outcomes from M in a small FIFO and serialises each one into a two-cycle read-modify-write of the BHR and PHT entries. It also sequences the post-reset clear of both tables by walking their indices, which replaces a bulk reset of the arrays. Two event counters report resolved branches and mispredictions.

## Interface
- BHT_DEPTH, 10, log2 BHT entries; index = pc[BHT_DEPTH+1:2]
- PHT_DEPTH, 6, BHR width and log2 PHT entries; must be ≤ BHT_DEPTH
- FIFO_DEPTH, 4, outcome queue entries; power of two
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- branchM  in  1  M-stage instruction is a branch
- stallM  in  1  M stage held this cycle; no enqueue
- pcM  in  32  PC of the M-stage branch
- actual_takeM  in  1  resolved direction
- pred_takeM  in  1  direction predicted in D, carried to M
- upd_stall  out  1  = branchM & ~stallM & full; pipeline holds M
- init_done  out  1  table clear complete
- bht_raddr  out  BHT_DEPTH  BHT read index (table read is combinational)
- bht_rdata  in  PHT_DEPTH  BHR at bht_raddr
- bht_we / bht_waddr / bht_wdata  out  1 / BHT_DEPTH / PHT_DEPTH  BHT write port
- pht_raddr  out  PHT_DEPTH  PHT read index
- pht_rdata  in  2  counter at pht_raddr
- pht_we / pht_waddr / pht_wdata  out  1 / PHT_DEPTH / 2  PHT write port
- branch_cnt  out  32  updates committed, wraps
- mispred_cnt  out  32  committed updates with pred ≠ actual, wraps

## Operation
- Counter encoding: SNT=00, WNT=01, WT=11, ST=10. The predicted direction is the MSB.
- Counter transitions: taken moves SNT→WNT→WT→ST, saturating at ST. Not-taken moves ST→WT→WNT→SNT, saturating at SNT.
- Enqueue: push {pcM[BHT_DEPTH+1:2], actual_takeM, pred_takeM} when branchM & ~stallM & ~full.
  - full is evaluated on the pre-edge count. A pop in the same cycle does not free a slot for that push.
- Push and pop in the same cycle are legal when the queue is not full; count is unchanged.
- FSM states: INIT, IDLE, READ, UPDATE.
- INIT
  - Counter idx runs 0 … 2^BHT_DEPTH−1.
  - Each cycle: bht_we=1, waddr=idx, wdata=0.
  - pht_we=1 only while idx < 2^PHT_DEPTH; waddr=idx[PHT_DEPTH-1:0], wdata=WT.
  - At the last idx, go to IDLE and set init_done=1, which stays set until rst.
  - The queue accepts pushes during INIT.
- IDLE: when the queue is non-empty, go to READ.
- READ
  - bht_raddr = head index.
  - Capture bhr_q = bht_rdata.
  - Go to UPDATE.
- UPDATE
  - pht_raddr = bhr_q.
  - pht_we=1, pht_waddr=bhr_q, pht_wdata = next(pht_rdata, taken).
  - bht_we=1, bht_waddr=head index, bht_wdata = {bhr_q[PHT_DEPTH-2:0], taken}.
  - Pop the head. branch_cnt += 1; mispred_cnt += (pred ≠ taken).
  - Next state is READ if the queue is non-empty after the pop, otherwise IDLE.
- Write enables are 0 in IDLE and READ.

## Timing
- Reset values while rst=1 and in the cycle it deasserts:
  - state INIT, idx=0, queue empty.
  - init_done=0, all *_we=0, upd_stall=0, both counters 0.
- The first INIT write occurs in the first cycle after rst deasserts. init_done rises 2^BHT_DEPTH cycles later.
- Push at edge E with FSM in IDLE:
  - IDLE in cycle E..E+1.
  - READ in cycle E+1..E+2.
  - UPDATE in cycle E+2..E+3; the tables commit at edge E+3.
- Throughput: one update per 2 cycles.
- Back-to-back entries with the same index: the second READ follows the first UPDATE's edge and sees the new BHR. No forwarding is needed.
- Reset mid-operation: rst asynchronously returns everything to reset values. The queue is discarded and the INIT walk restarts at 0.
- Counter wrap: 0xFFFFFFFF + 1 = 0.

## Structure
- Package bp_pkg holds:
  - counter encodings SNT/WNT/WT/ST
  - FSM state enum
  - default depths
  - function next_ctr(ctr, taken)
- Sub-module bp_upd_fifo: FIFO_DEPTH × (BHT_DEPTH+2) circular buffer.
  - Pointers are log2(FIFO_DEPTH)+1 bits with wrap bit.
  - Outputs full, empty, head.
- All remaining logic lives in bp_update_ctrl.

## Test plan
- Reset clear: release rst → 1024 cycles of bht_we with addr 0…1023, wdata 0 → pht_we only on the first 64 cycles with wdata 11 → init_done high at cycle 1024.
- Single update: after init, BHT[5]=0, PHT[0]=WT; push pcM=0x14, taken=1 → READ at E+1, UPDATE at E+2 → pht_wdata=10, bht_wdata=000001.
- Saturation and mispredict: five not-taken pushes to one pc starting from ST → PHT counters walk to SNT and hold. mispred_cnt counts according to the pred_takeM values driven.
- Full queue: 5 unstalled branches pushed in consecutive cycles → upd_stall=1 on the 5th. That push is accepted on the first cycle after a pop frees a slot; no entry is lost or duplicated.
- Simultaneous push/pop with count=2 → count stays 2 and FIFO order is preserved.
- rst mid-UPDATE with 3 entries queued → no write on the aborted edge, queue empty, and a fresh INIT starts at idx 0.
